// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_pkg
// Description : Definitions shared by the shift_tx transmitter and its
//               receiving universal shift register. This package holds the
//               receiver mode encoding that is carried on S_out, the
//               transmitter FSM state encoding, and a helper that maps the
//               bit order onto the matching receiver shift direction.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_pkg;

  // Receiver mode encoding. It must stay bit-identical to the receiver's
  // S input.
  localparam logic [1:0] NO_CHANGE     = 2'b00;
  localparam logic [1:0] SHIFT_RIGHT   = 2'b01;
  localparam logic [1:0] SHIFT_LEFT    = 2'b10;
  localparam logic [1:0] PARALLEL_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2
  } state_t;

  // LSB-first frames enter the receiver from the top. The receiver therefore
  // shifts right for them. MSB-first frames enter at bit 0, so the receiver
  // shifts left.
  function automatic logic [1:0] shift_mode(input logic msb_first);
    return msb_first ? SHIFT_LEFT : SHIFT_RIGHT;
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_tx_baud.sv
`default_nettype none
// ============================================================================
// Module      : shift_tx_baud
// Description : Bit-period divider for shift_tx. It counts DIV clocks per bit
//               period. strobe_o marks the last cycle of the current period.
//               strobe_next_o reports whether the following cycle will be a
//               strobe, which lets the transmitter register outputs that line
//               up with the strobe.
// Ports       : clk, rstn        clock, async active-low reset
//               clear_i          restart the period (frame accepted)
//               en_i             count (frame in progress)
//               strobe_o         this cycle ends a bit period
//               strobe_next_o    next cycle ends a bit period
// Revision    : 1.0 - initial release
// ============================================================================
module shift_tx_baud #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear_i,
  input  logic en_i,
  output logic strobe_o,
  output logic strobe_next_o
);

  localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DCW-1:0] DIV_MAX = DCW'(DIV - 1);

  logic [DCW-1:0] div_cnt_q;
  logic [DCW-1:0] div_cnt_d;

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (clear_i) begin
      div_cnt_d = '0;
    end else if (en_i) begin
      div_cnt_d = (div_cnt_q == DIV_MAX) ? '0 : div_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  assign strobe_o      = en_i && (div_cnt_q == DIV_MAX);
  assign strobe_next_o = (div_cnt_d == DIV_MAX);

endmodule
`default_nettype wire

// File: rtl/shift_tx.sv
`default_nettype none
// ============================================================================
// Module      : shift_tx
// Description : Parallel-to-serial transmitter. It accepts one SIZE-bit word
//               per valid/ready handshake and sends the word on SO, one bit
//               per DIV-clock bit period, LSB- or MSB-first. On the last
//               cycle of each bit period it drives S_out so that a downstream
//               universal shift register (SI<=SO, S<=S_out) captures the word.
//               Build option SHIFT_TX_PARITY_EN appends one even-parity bit
//               period. S_out holds 00 during that period, and the option
//               adds the par_strobe output.
// Ports       : clk, rstn   clock, async active-low reset
//               PI          parallel word        in_valid   word valid
//               msb_first   bit order at accept  in_ready   can accept
//               SO          serial bit           S_out      receiver mode
//               busy        frame in progress    done       last strobe pulse
//               par_strobe  parity period end (SHIFT_TX_PARITY_EN only)
// Revision    : 1.0 - initial release
// ============================================================================
module shift_tx
  import shift_pkg::*;
#(
  parameter int SIZE = 4,
  parameter int DIV  = 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [SIZE-1:0] PI,
  input  logic            in_valid,
  input  logic            msb_first,
  output logic            in_ready,
  output logic            SO,
  output logic [1:0]      S_out,
  output logic            busy,
  output logic            done
`ifdef SHIFT_TX_PARITY_EN
  ,output logic           par_strobe
`endif
);

  localparam int BCW = $clog2(SIZE + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(SIZE - 1);
  localparam logic [BCW-1:0] PENULT   = BCW'(SIZE - 2);

  state_t          state_q;
  logic [SIZE-1:0] shreg_q;
  logic            msb_q;
  logic [BCW-1:0]  bit_cnt_q;
`ifdef SHIFT_TX_PARITY_EN
  logic            parity_q;
`endif

  logic            w_accept;
  logic            w_strobe;
  logic            w_strobe_next;
  logic [SIZE-1:0] w_shifted;

  assign w_accept  = (state_q == ST_IDLE) && in_valid && in_ready;
  assign w_shifted = msb_q ? {shreg_q[SIZE-2:0], 1'b0} : {1'b0, shreg_q[SIZE-1:1]};

  shift_tx_baud #(.DIV(DIV)) u_baud (
    .clk           (clk),
    .rstn          (rstn),
    .clear_i       (w_accept),
    .en_i          (state_q != ST_IDLE),
    .strobe_o      (w_strobe),
    .strobe_next_o (w_strobe_next)
  );

  // The outputs are registered. They are computed one cycle early so that
  // S_out, done and par_strobe show during the strobe cycle itself.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      msb_q      <= 1'b0;
      bit_cnt_q  <= '0;
      SO         <= 1'b0;
      S_out      <= NO_CHANGE;
      busy       <= 1'b0;
      done       <= 1'b0;
      in_ready   <= 1'b1;
`ifdef SHIFT_TX_PARITY_EN
      parity_q   <= 1'b0;
      par_strobe <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef SHIFT_TX_PARITY_EN
      par_strobe <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (w_accept) begin
            state_q   <= ST_SHIFT;
            shreg_q   <= PI;
            msb_q     <= msb_first;
            bit_cnt_q <= '0;
            SO        <= msb_first ? PI[SIZE-1] : PI[0];
            S_out     <= w_strobe_next ? shift_mode(msb_first) : NO_CHANGE;
            busy      <= 1'b1;
            in_ready  <= 1'b0;
`ifdef SHIFT_TX_PARITY_EN
            parity_q  <= ^PI;
`endif
          end
        end

        ST_SHIFT: begin
          if (w_strobe) begin
            if (bit_cnt_q == LAST_BIT) begin
`ifdef SHIFT_TX_PARITY_EN
              state_q    <= ST_PAR;
              SO         <= parity_q;
              S_out      <= NO_CHANGE;
              par_strobe <= w_strobe_next;
              done       <= w_strobe_next;
`else
              state_q  <= ST_IDLE;
              SO       <= 1'b0;
              S_out    <= NO_CHANGE;
              busy     <= 1'b0;
              in_ready <= 1'b1;
`endif
            end else begin
              shreg_q   <= w_shifted;
              SO        <= msb_q ? w_shifted[SIZE-1] : w_shifted[0];
              bit_cnt_q <= bit_cnt_q + 1'b1;
              S_out     <= w_strobe_next ? shift_mode(msb_q) : NO_CHANGE;
`ifndef SHIFT_TX_PARITY_EN
              done      <= w_strobe_next && (bit_cnt_q == PENULT);
`endif
            end
          end else begin
            S_out <= w_strobe_next ? shift_mode(msb_q) : NO_CHANGE;
`ifndef SHIFT_TX_PARITY_EN
            done  <= w_strobe_next && (bit_cnt_q == LAST_BIT);
`endif
          end
        end

`ifdef SHIFT_TX_PARITY_EN
        ST_PAR: begin
          if (w_strobe) begin
            state_q  <= ST_IDLE;
            SO       <= 1'b0;
            busy     <= 1'b0;
            in_ready <= 1'b1;
          end else begin
            par_strobe <= w_strobe_next;
            done       <= w_strobe_next;
          end
        end
`endif

        default: begin
          state_q  <= ST_IDLE;
          SO       <= 1'b0;
          S_out    <= NO_CHANGE;
          busy     <= 1'b0;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
